// File: rtl/pipe_port_sequencer.sv
// Table-driven stimulus sequencer for the pipelined_computer input ports.
// Each channel replays its own {value, hold, last} table; a shared FSM sequences the run.

module pipe_port_channel #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 16,
    parameter int AW     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_value,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic              wr_last,
    input  logic              launch,
    input  logic              advance,
    input  logic              loop_en,
    output logic [WIDTH-1:0]  value,
    output logic              strobe,
    output logic              fin_next
);
    logic [WIDTH-1:0]  tbl_value [DEPTH];
    logic [HOLD_W-1:0] tbl_hold  [DEPTH];
    logic [DEPTH-1:0]  tbl_last;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     idx_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              fin;
    logic              is_last;
    logic              expired;

    // The final table slot always terminates, even with no last bit written.
    assign is_last  = tbl_last[idx] || (idx == AW'(DEPTH - 1));
    assign expired  = (hold_cnt == '0);
    assign idx_nxt  = is_last ? '0 : idx + 1'b1;
    assign fin_next = fin || (expired && is_last && !loop_en);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_value[i] <= '0;
                tbl_hold[i]  <= '0;
            end
            tbl_last <= '0;
        end else if (wr_en) begin
            tbl_value[wr_addr] <= wr_value;
            tbl_hold[wr_addr]  <= wr_hold;
            tbl_last[wr_addr]  <= wr_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            hold_cnt <= '0;
            value    <= '0;
            strobe   <= 1'b0;
            fin      <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (launch) begin
                idx      <= '0;
                value    <= tbl_value[0];
                hold_cnt <= tbl_hold[0];
                strobe   <= 1'b1;
                fin      <= 1'b0;
            end else if (advance && !fin) begin
                if (!expired) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end else if (!is_last || loop_en) begin
                    idx      <= idx_nxt;
                    value    <= tbl_value[idx_nxt];
                    hold_cnt <= tbl_hold[idx_nxt];
                    strobe   <= 1'b1;
                end else begin
                    fin <= 1'b1;
                end
            end
        end
    end
endmodule

module pipe_port_sequencer #(
    parameter int NCH    = 2,
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 16,
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_value,
    input  logic [HOLD_W-1:0]    cfg_hold,
    input  logic                 cfg_last,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    output logic [NCH*WIDTH-1:0] in_port,
    output logic [NCH-1:0]       step_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          cycle_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state;
    logic           loop_q;
    logic           launch;
    logic           advance;
    logic           wr_ok;
    logic [NCH-1:0] fin_next;

    // stop dominates start; start is only honoured outside RUN.
    assign launch  = (state != S_RUN) && start && !stop;
    assign advance = (state == S_RUN) && !stop;
    assign wr_ok   = cfg_we && !busy
                     && ({1'b0, cfg_ch} < (CHW + 1)'(NCH))
                     && ({1'b0, cfg_addr} < (AW + 1)'(DEPTH));

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            pipe_port_channel #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .HOLD_W(HOLD_W),
                .AW    (AW)
            ) u_ch (
                .clock   (clock),
                .reset   (reset),
                .wr_en   (wr_ok && (cfg_ch == CHW'(c))),
                .wr_addr (cfg_addr),
                .wr_value(cfg_value),
                .wr_hold (cfg_hold),
                .wr_last (cfg_last),
                .launch  (launch),
                .advance (advance),
                .loop_en (loop_q),
                .value   (in_port[c*WIDTH +: WIDTH]),
                .strobe  (step_strobe[c]),
                .fin_next(fin_next[c])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            loop_q      <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (&fin_next) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        loop_q      <= loop;
                        cycle_count <= 32'd1;
                    end
                end
            endcase
        end
    end
endmodule
